// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: advances, holds, bubbles or kills a payload
// under the shared stall vector, and returns a multi-cycle side channel to the upstream stage.
module pipe_stage_reg #(
   parameter int unsigned       DATA_W    = 128,
   parameter int unsigned       SIDE_W    = 66,
   parameter int unsigned       DBG_W     = 32,
   parameter int unsigned       STALL_W   = 6,
   parameter int unsigned       STAGE     = 3,
   parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
   parameter int unsigned       CNT_W     = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_payload,
   input  logic [SIDE_W-1:0]  in_side,
   input  logic [DBG_W-1:0]   in_dbg,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_payload,
   output logic [SIDE_W-1:0]  out_side,
   output logic [DBG_W-1:0]   out_dbg,
   output logic [CNT_W-1:0]   hold_cnt,
   output logic [CNT_W-1:0]   bubble_cnt,
   output logic               stall_err
);

   logic              up_stall;
   logic              dn_stall;

   logic              valid_d,   valid_q;
   logic [DATA_W-1:0] payload_d, payload_q;
   logic [SIDE_W-1:0] side_d,    side_q;
   logic [DBG_W-1:0]  dbg_d,     dbg_q;
   logic [CNT_W-1:0]  hold_d,    hold_q;
   logic [CNT_W-1:0]  bubble_d,  bubble_q;
   logic              err_d,     err_q;

   assign up_stall = stall[STAGE];
   assign dn_stall = stall[STAGE+1];

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_comb begin
      valid_d   = valid_q;
      payload_d = payload_q;
      side_d    = side_q;
      dbg_d     = dbg_q;
      hold_d    = hold_q;
      bubble_d  = bubble_q;
      err_d     = err_q;
      if (rst) begin
         valid_d   = 1'b0;
         payload_d = NOP_VALUE;
         side_d    = '0;
         dbg_d     = '0;
         hold_d    = '0;
         bubble_d  = '0;
         err_d     = 1'b0;
      end else if (flush) begin
         valid_d   = 1'b0;
         payload_d = NOP_VALUE;
         side_d    = '0;
         dbg_d     = '0;
      end else if (up_stall && !dn_stall) begin
         // downstream keeps running, so it gets a NOP while upstream iterates
         valid_d   = 1'b0;
         payload_d = NOP_VALUE;
         side_d    = in_side;
         dbg_d     = in_dbg;
         bubble_d  = sat_inc(bubble_q);
      end else if (!up_stall) begin
         valid_d   = in_valid;
         payload_d = in_payload;
         side_d    = '0;
         dbg_d     = in_dbg;
         if (dn_stall) begin
            err_d = 1'b1;
         end
      end else begin
         side_d = in_side;
         hold_d = sat_inc(hold_q);
      end
   end

   always_ff @(posedge clk) begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      side_q    <= side_d;
      dbg_q     <= dbg_d;
      hold_q    <= hold_d;
      bubble_q  <= bubble_d;
      err_q     <= err_d;
   end

   assign out_valid   = valid_q;
   assign out_payload = payload_q;
   assign out_side    = side_q;
   assign out_dbg     = dbg_q;
   assign hold_cnt    = hold_q;
   assign bubble_cnt  = bubble_q;
   assign stall_err   = err_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed steps then random traffic, checked against a
// priority-rule reference model; a second instance with 2-bit counters covers saturation.
module tb_pipe_stage_reg;

   logic          clk = 1'b0;
   logic          rst;
   logic [5:0]    stall;
   logic          flush;
   logic          in_valid;
   logic [127:0]  in_payload;
   logic [65:0]   in_side;
   logic [31:0]   in_dbg;

   logic          out_valid;
   logic [127:0]  out_payload;
   logic [65:0]   out_side;
   logic [31:0]   out_dbg;
   logic [15:0]   hold_cnt;
   logic [15:0]   bubble_cnt;
   logic          stall_err;

   logic          out_valid2;
   logic [127:0]  out_payload2;
   logic [65:0]   out_side2;
   logic [31:0]   out_dbg2;
   logic [1:0]    hold_cnt2;
   logic [1:0]    bubble_cnt2;
   logic          stall_err2;

   int errors = 0;
   int checks = 0;

   // reference state
   logic          m_valid;
   logic [127:0]  m_payload;
   logic [65:0]   m_side;
   logic [31:0]   m_dbg;
   int            m_hold, m_bub, m_hold2, m_bub2;
   logic          m_err;

   always #5 clk = ~clk;

   pipe_stage_reg u_dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_payload(in_payload), .in_side(in_side), .in_dbg(in_dbg),
      .out_valid(out_valid), .out_payload(out_payload), .out_side(out_side), .out_dbg(out_dbg),
      .hold_cnt(hold_cnt), .bubble_cnt(bubble_cnt), .stall_err(stall_err)
   );

   pipe_stage_reg #(.CNT_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_payload(in_payload), .in_side(in_side), .in_dbg(in_dbg),
      .out_valid(out_valid2), .out_payload(out_payload2), .out_side(out_side2), .out_dbg(out_dbg2),
      .hold_cnt(hold_cnt2), .bubble_cnt(bubble_cnt2), .stall_err(stall_err2)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: one action per edge, chosen by plain priority on rst/flush/S/D.
   task automatic model_edge();
      bit s, d;
      s = stall[3];
      d = stall[4];
      if (rst) begin
         m_valid = 0; m_payload = '0; m_side = '0; m_dbg = '0;
         m_hold = 0; m_bub = 0; m_hold2 = 0; m_bub2 = 0; m_err = 0;
      end else if (flush) begin
         m_valid = 0; m_payload = '0; m_side = '0; m_dbg = '0;
      end else if (s && !d) begin
         m_valid = 0; m_payload = '0; m_side = in_side; m_dbg = in_dbg;
         m_bub  = (m_bub  < 65535) ? m_bub  + 1 : m_bub;
         m_bub2 = (m_bub2 < 3)     ? m_bub2 + 1 : m_bub2;
      end else if (!s) begin
         m_valid = in_valid; m_payload = in_payload; m_side = '0; m_dbg = in_dbg;
         if (d) m_err = 1;
      end else begin
         m_side  = in_side;
         m_hold  = (m_hold  < 65535) ? m_hold  + 1 : m_hold;
         m_hold2 = (m_hold2 < 3)     ? m_hold2 + 1 : m_hold2;
      end
   endtask

   task automatic compare_all();
      check("out_valid",   128'(out_valid),   128'(m_valid));
      check("out_payload", out_payload,       m_payload);
      check("out_side",    128'(out_side),    128'(m_side));
      check("out_dbg",     128'(out_dbg),     128'(m_dbg));
      check("hold_cnt",    128'(hold_cnt),    128'(m_hold));
      check("bubble_cnt",  128'(bubble_cnt),  128'(m_bub));
      check("stall_err",   128'(stall_err),   128'(m_err));
      check("hold_cnt_w2", 128'(hold_cnt2),   128'(m_hold2));
      check("bubble_cnt_w2", 128'(bubble_cnt2), 128'(m_bub2));
   endtask

   task automatic step(input logic r, input logic [5:0] st, input logic fl,
                       input logic v, input logic [127:0] p, input logic [65:0] sd,
                       input logic [31:0] dg);
      @(negedge clk);
      rst = r; stall = st; flush = fl;
      in_valid = v; in_payload = p; in_side = sd; in_dbg = dg;
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   localparam logic [5:0] RUN  = 6'b000000;
   localparam logic [5:0] HOLD = 6'b011000;
   localparam logic [5:0] BUBL = 6'b001000;
   localparam logic [5:0] ILL  = 6'b010000;

   initial begin
      logic [127:0] rnd;
      logic [5:0]   st;
      rst = 1; stall = '0; flush = 0; in_valid = 0;
      in_payload = '0; in_side = '0; in_dbg = '0;

      step(1, RUN, 0, 1, 128'hdead, 66'h5, 32'h77);
      step(1, HOLD, 1, 1, 128'hbeef, 66'h6, 32'h78);
      check("reset_payload_nop", out_payload, 128'h0);
      check("reset_hold_zero", 128'(hold_cnt), 128'h0);

      for (int i = 1; i <= 4; i++)
         step(0, RUN, 0, 1, 128'(i), 66'(i + 16), 32'(i + 100));
      check("stream_last", out_payload, 128'h4);

      step(0, RUN, 0, 1, 128'hA, 66'h0, 32'hA0);
      for (int i = 0; i < 3; i++)
         step(0, HOLD, 0, 0, 128'(i + 50), 66'(i + 7), 32'(i + 200));
      check("hold_payload", out_payload, 128'hA);
      check("hold_count3", 128'(hold_cnt), 128'd3);
      check("hold_side", 128'(out_side), 128'd9);

      step(0, BUBL, 0, 1, 128'h33, 66'h1_0000_0000_0000_0005, 32'h1);
      check("madd_side", 128'(out_side), 128'h1_0000_0000_0000_0005);
      check("madd_bubble1", 128'(bubble_cnt), 128'd1);
      step(0, RUN, 0, 1, 128'h34, 66'h3, 32'h2);
      check("madd_adv_side", 128'(out_side), 128'h0);

      step(0, HOLD, 1, 1, 128'h35, 66'h9, 32'h3);
      check("flush_hold_cnt", 128'(hold_cnt), 128'd3);
      check("flush_valid", 128'(out_valid), 128'h0);

      step(0, ILL, 0, 1, 128'h36, 66'h4, 32'h4);
      check("illegal_err", 128'(stall_err), 128'h1);
      check("illegal_adv", out_payload, 128'h36);
      step(0, RUN, 1, 1, 128'h37, 66'h4, 32'h5);
      check("err_sticky_flush", 128'(stall_err), 128'h1);
      step(1, RUN, 0, 1, 128'h38, 66'h4, 32'h6);
      check("err_cleared", 128'(stall_err), 128'h0);

      for (int i = 0; i < 5; i++) begin
         step(0, BUBL, 0, 1, 128'(i), 66'(i), 32'(i));
         check("sat_bubble_w2", 128'(bubble_cnt2), 128'((i < 2) ? i + 1 : 3));
      end

      for (int i = 0; i < 400; i++) begin
         rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
         st  = 6'($urandom());
         step(($urandom_range(0, 39) == 0), st, ($urandom_range(0, 9) == 0),
              1'($urandom()), rnd, {rnd[1:0], rnd[127:64]}, rnd[95:64]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
